// File: rtl/i2c_bus_scheduler.sv
// Round-robin arbiter that shares one byte-level I2C command engine between NREQ requesters.
// Each granted transaction issues START, address/RW, data bytes and STOP, one command in flight at a time.
module i2c_bus_scheduler #(
    parameter int NREQ = 4,
    parameter int LENW = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*7-1:0]    req_addr_i,
    input  logic [NREQ-1:0]      req_op_i,
    input  logic [NREQ*LENW-1:0] req_len_i,
    input  logic [NREQ*8-1:0]    wdata_i,
    input  logic [NREQ-1:0]      wdata_valid_i,
    output logic [NREQ-1:0]      wdata_ready_o,
    output logic [7:0]           rdata_o,
    output logic [NREQ-1:0]      rdata_valid_o,
    output logic [NREQ-1:0]      done_o,
    output logic                 err_o,
    output logic [NREQ-1:0]      grant_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [2:0]           cmd_o,
    output logic [7:0]           cmd_data_o,
    input  logic                 rsp_valid_i,
    input  logic [7:0]           rsp_data_i,
    input  logic                 rsp_nak_i
);
    localparam int IDXW = $clog2(NREQ);

    localparam logic [2:0] CMD_START    = 3'd0;
    localparam logic [2:0] CMD_STOP     = 3'd1;
    localparam logic [2:0] CMD_WRITE    = 3'd2;
    localparam logic [2:0] CMD_READ_ACK = 3'd3;
    localparam logic [2:0] CMD_READ_NAK = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic              wait_reg, wait_next;
    logic [IDXW-1:0]   idx_reg, idx_next;
    logic [NREQ-1:0]   grant_reg, grant_next;
    logic [6:0]        addr_reg, addr_next;
    logic              op_reg, op_next;
    logic [LENW-1:0]   remain_reg, remain_next;
    logic              err_reg, err_next;
    logic [IDXW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [7:0]        rdata_reg, rdata_next;
    logic [NREQ-1:0]   rdata_valid_reg, rdata_valid_next;

    logic [6:0]        addr_arr  [NREQ];
    logic [LENW-1:0]   len_arr   [NREQ];
    logic [7:0]        wdata_arr [NREQ];

    logic              arb_found;
    logic [IDXW-1:0]   arb_idx;
    logic [IDXW-1:0]   cand;
    logic              cmd_fire;
    logic              rsp_fire;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr_i[7*gi +: 7];
        assign len_arr[gi]   = req_len_i[LENW*gi +: LENW];
        assign wdata_arr[gi] = wdata_i[8*gi +: 8];
    end

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDXW'((int'(rr_ptr_reg) + i) % NREQ);
            if (req_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        cmd_valid_o   = 1'b0;
        cmd_o         = CMD_START;
        cmd_data_o    = 8'h00;
        wdata_ready_o = '0;
        done_o        = '0;
        err_o         = 1'b0;
        if (!wait_reg) begin
            case (state_reg)
                S_START: cmd_valid_o = 1'b1;
                S_ADDR: begin
                    cmd_valid_o = 1'b1;
                    cmd_o       = CMD_WRITE;
                    cmd_data_o  = {addr_reg, op_reg};
                end
                S_WDATA: begin
                    cmd_valid_o = wdata_valid_i[idx_reg];
                    cmd_o       = CMD_WRITE;
                    cmd_data_o  = wdata_arr[idx_reg];
                    if (wdata_valid_i[idx_reg] && cmd_ready_i) begin
                        wdata_ready_o = grant_reg;
                    end
                end
                S_RDATA: begin
                    cmd_valid_o = 1'b1;
                    cmd_o       = (remain_reg == LENW'(1)) ? CMD_READ_NAK : CMD_READ_ACK;
                end
                S_STOP: begin
                    cmd_valid_o = 1'b1;
                    cmd_o       = CMD_STOP;
                end
                default: ;
            endcase
        end
        if (state_reg == S_DONE) begin
            done_o = grant_reg;
            err_o  = err_reg;
        end
    end

    assign cmd_fire = cmd_valid_o & cmd_ready_i;
    // Responses only count while a command is outstanding.
    assign rsp_fire = wait_reg & rsp_valid_i;

    always_comb begin
        state_next       = state_reg;
        wait_next        = wait_reg;
        idx_next         = idx_reg;
        grant_next       = grant_reg;
        addr_next        = addr_reg;
        op_next          = op_reg;
        remain_next      = remain_reg;
        err_next         = err_reg;
        rr_ptr_next      = rr_ptr_reg;
        rdata_next       = rdata_reg;
        rdata_valid_next = '0;
        if (cmd_fire) begin
            wait_next = 1'b1;
        end
        if (rsp_fire) begin
            wait_next = 1'b0;
        end
        case (state_reg)
            S_IDLE: begin
                if (|req_i) state_next = S_ARB;
            end
            S_ARB: begin
                if (arb_found) begin
                    idx_next            = arb_idx;
                    grant_next          = '0;
                    grant_next[arb_idx] = 1'b1;
                    addr_next           = addr_arr[arb_idx];
                    op_next             = req_op_i[arb_idx];
                    remain_next         = len_arr[arb_idx];
                    err_next            = 1'b0;
                    state_next          = S_START;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_START: begin
                if (rsp_fire) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (rsp_fire) begin
                    if (rsp_nak_i) begin
                        err_next   = 1'b1;
                        state_next = S_STOP;
                    end else if (remain_reg == '0) begin
                        state_next = S_STOP;
                    end else begin
                        state_next = op_reg ? S_RDATA : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (rsp_fire) begin
                    remain_next = remain_reg - LENW'(1);
                    if (rsp_nak_i) begin
                        err_next   = 1'b1;
                        state_next = S_STOP;
                    end else if (remain_reg == LENW'(1)) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_RDATA: begin
                if (rsp_fire) begin
                    rdata_next       = rsp_data_i;
                    rdata_valid_next = grant_reg;
                    remain_next      = remain_reg - LENW'(1);
                    if (remain_reg == LENW'(1)) state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (rsp_fire) state_next = S_DONE;
            end
            S_DONE: begin
                rr_ptr_next = (idx_reg == IDXW'(NREQ - 1)) ? '0 : idx_reg + IDXW'(1);
                grant_next  = '0;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= S_IDLE;
            wait_reg        <= 1'b0;
            idx_reg         <= '0;
            grant_reg       <= '0;
            addr_reg        <= '0;
            op_reg          <= 1'b0;
            remain_reg      <= '0;
            err_reg         <= 1'b0;
            rr_ptr_reg      <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= '0;
        end else begin
            state_reg       <= state_next;
            wait_reg        <= wait_next;
            idx_reg         <= idx_next;
            grant_reg       <= grant_next;
            addr_reg        <= addr_next;
            op_reg          <= op_next;
            remain_reg      <= remain_next;
            err_reg         <= err_next;
            rr_ptr_reg      <= rr_ptr_next;
            rdata_reg       <= rdata_next;
            rdata_valid_reg <= rdata_valid_next;
        end
    end

    assign grant_o       = grant_reg;
    assign rdata_o       = rdata_reg;
    assign rdata_valid_o = rdata_valid_reg;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Directed bench for i2c_bus_scheduler: a scripted engine logs accepted commands, the main
// sequence compares command streams, grants, read data and completion status against hand values.
module tb_i2c_bus_scheduler;
    localparam int NREQ = 4;
    localparam int LENW = 4;

    localparam logic [2:0] C_START = 3'd0;
    localparam logic [2:0] C_STOP  = 3'd1;
    localparam logic [2:0] C_WRITE = 3'd2;
    localparam logic [2:0] C_RACK  = 3'd3;
    localparam logic [2:0] C_RNAK  = 3'd4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*7-1:0]    req_addr_i;
    logic [NREQ-1:0]      req_op_i;
    logic [NREQ*LENW-1:0] req_len_i;
    logic [NREQ*8-1:0]    wdata_i;
    logic [NREQ-1:0]      wdata_valid_i;
    logic [NREQ-1:0]      wdata_ready_o;
    logic [7:0]           rdata_o;
    logic [NREQ-1:0]      rdata_valid_o;
    logic [NREQ-1:0]      done_o;
    logic                 err_o;
    logic [NREQ-1:0]      grant_o;
    logic                 cmd_valid_o;
    logic                 cmd_ready_i;
    logic [2:0]           cmd_o;
    logic [7:0]           cmd_data_o;
    logic                 rsp_valid_i;
    logic [7:0]           rsp_data_i;
    logic                 rsp_nak_i;

    i2c_bus_scheduler #(.NREQ(NREQ), .LENW(LENW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .req_addr_i    (req_addr_i),
        .req_op_i      (req_op_i),
        .req_len_i     (req_len_i),
        .wdata_i       (wdata_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .grant_o       (grant_o),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_ready_i   (cmd_ready_i),
        .cmd_o         (cmd_o),
        .cmd_data_o    (cmd_data_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_data_i    (rsp_data_i),
        .rsp_nak_i     (rsp_nak_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Engine configuration (written by the main sequence) and engine logs (written by the engine).
    int          bp_cycles = 0;
    int          nak_at    = -1;
    logic [7:0]  wbytes [16];
    logic [7:0]  rbytes [16];
    logic [10:0] cmd_log [$];
    logic [11:0] rd_log [$];
    logic [10:0] exp_q [$];
    int          stable_err = 0;
    int          early_err  = 0;
    int          wr_pulses  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag, input int base);
        logic [10:0] g;
        check({tag, "_count"}, 64'(cmd_log.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < cmd_log.size(); i++) begin
            g = cmd_log[base + i];
            if (exp_q[i][10:8] != C_WRITE) g[7:0] = 8'h00;
            check($sformatf("%s_cmd%0d", tag, i), 64'(g), 64'(exp_q[i]));
        end
    endtask

    task automatic set_req(input int k, input logic [6:0] a, input logic op, input logic [LENW-1:0] len);
        req_addr_i[7*k +: 7]       = a;
        req_op_i[k]                = op;
        req_len_i[LENW*k +: LENW]  = len;
        req_i[k]                   = 1'b1;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] d, output logic e);
        int n;
        n = 0;
        d = '0;
        e = 1'b0;
        @(negedge clk_i);
        while (done_o == '0 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (done_o == '0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            d     = done_o;
            e     = err_o;
            req_i = req_i & ~done_o;
            $display("txn done=%b err=%b t=%0t", d, e, $time);
        end
    endtask

    // Scripted engine: optional backpressure, two idle cycles, then one response per accepted command.
    initial begin : engine
        int          cmd_num;
        int          wptr;
        int          rptr;
        logic [2:0]  c0;
        logic [7:0]  d0;
        logic [2:0]  c_acc;
        bit          aborted;
        bit          wr_adv;
        cmd_num = 0; wptr = 0; rptr = 0;
        cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_nak_i = 1'b0; rsp_data_i = 8'h00;
        wdata_i = '0;
        forever begin
            @(negedge clk_i);
            rsp_valid_i = 1'b0; rsp_nak_i = 1'b0; rsp_data_i = 8'h00; cmd_ready_i = 1'b0;
            if (rst_i === 1'b1 && cmd_valid_o === 1'b1) begin
                c0 = cmd_o; d0 = cmd_data_o; aborted = 1'b0;
                for (int k = 0; k < bp_cycles; k++) begin
                    @(negedge clk_i);
                    if (rst_i !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (cmd_valid_o !== 1'b1 || cmd_o !== c0 || cmd_data_o !== d0) stable_err++;
                end
                if (!aborted) begin
                    cmd_ready_i = 1'b1;
                    #1;
                    c_acc = cmd_o;
                    cmd_log.push_back({cmd_o, cmd_data_o});
                    wr_adv = (wdata_ready_o != '0);
                    if (wr_adv) wr_pulses++;
                    if (c_acc == C_START) begin
                        cmd_num = 0; wptr = 0; rptr = 0;
                    end else begin
                        cmd_num++;
                    end
                    @(negedge clk_i);
                    cmd_ready_i = 1'b0;
                    if (wr_adv) wptr++;
                    wdata_i = {NREQ{wbytes[wptr & 15]}};
                    if (rst_i === 1'b1 && cmd_valid_o === 1'b1) early_err++;
                    @(negedge clk_i);
                    if (rst_i === 1'b1 && cmd_valid_o === 1'b1) early_err++;
                    if (rst_i === 1'b1) begin
                        rsp_valid_i = 1'b1;
                        rsp_nak_i   = (cmd_num == nak_at);
                        if (c_acc == C_RACK || c_acc == C_RNAK) begin
                            rsp_data_i = rbytes[rptr & 15];
                            rptr++;
                        end
                    end
                end
            end
        end
    end

    initial begin : rdata_monitor
        forever begin
            @(negedge clk_i);
            if (rdata_valid_o != '0) rd_log.push_back({rdata_valid_o, rdata_o});
        end
    end

    initial begin : main
        logic [NREQ-1:0] d;
        logic            e;
        int              base;
        int              rd_base;
        int              wp_base;
        int              n;
        for (int i = 0; i < 16; i++) begin
            wbytes[i] = 8'h00;
            rbytes[i] = 8'h00;
        end
        rst_i = 1'b0; req_i = '0; req_addr_i = '0; req_op_i = '0; req_len_i = '0;
        wdata_valid_i = '1;
        repeat (3) @(negedge clk_i);
        check("reset_outputs", 64'({grant_o, cmd_valid_o, cmd_o, cmd_data_o, rdata_o,
              rdata_valid_o, wdata_ready_o, done_o, err_o}), 64'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Round-robin: three probes from rr_ptr 0, then a req2 probe moves the pointer to 3.
        base = cmd_log.size();
        set_req(0, 7'h01, 1'b0, 4'd0);
        set_req(1, 7'h02, 1'b0, 4'd0);
        set_req(3, 7'h03, 1'b0, 4'd0);
        wait_done(d, e); check("rr_first", 64'(d), 64'(4'b0001));
        wait_done(d, e); check("rr_second", 64'(d), 64'(4'b0010));
        wait_done(d, e); check("rr_third", 64'(d), 64'(4'b1000));
        check("rr_probe_cmds", 64'(cmd_log.size() - base), 64'd9);
        @(negedge clk_i);
        set_req(2, 7'h04, 1'b0, 4'd0);
        wait_done(d, e); check("rr_req2", 64'(d), 64'(4'b0100));
        @(negedge clk_i);
        set_req(0, 7'h05, 1'b0, 4'd0);
        set_req(3, 7'h06, 1'b0, 4'd0);
        wait_done(d, e); check("rr_wrap_first", 64'(d), 64'(4'b1000));
        wait_done(d, e); check("rr_wrap_second", 64'(d), 64'(4'b0001));

        // Single write with grant latency check.
        @(negedge clk_i);
        wbytes[0] = 8'hA5; wbytes[1] = 8'h5A;
        base = cmd_log.size(); wp_base = wr_pulses;
        set_req(0, 7'h22, 1'b0, 4'd2);
        @(negedge clk_i);
        check("wr_grant_arb", 64'(grant_o), 64'd0);
        @(negedge clk_i);
        check("wr_grant_start", 64'({grant_o, cmd_valid_o, cmd_o}), 64'({4'b0001, 1'b1, C_START}));
        wait_done(d, e);
        check("wr_done", 64'({d, e}), 64'({4'b0001, 1'b0}));
        exp_q = '{{C_START, 8'h00}, {C_WRITE, 8'h44}, {C_WRITE, 8'hA5}, {C_WRITE, 8'h5A}, {C_STOP, 8'h00}};
        check_log("wr", base);
        check("wr_ready_pulses", 64'(wr_pulses - wp_base), 64'd2);

        // Single read of three bytes.
        @(negedge clk_i);
        rbytes[0] = 8'h01; rbytes[1] = 8'h02; rbytes[2] = 8'h03;
        base = cmd_log.size(); rd_base = rd_log.size();
        set_req(2, 7'h10, 1'b1, 4'd3);
        wait_done(d, e);
        check("rd_done", 64'({d, e}), 64'({4'b0100, 1'b0}));
        exp_q = '{{C_START, 8'h00}, {C_WRITE, 8'h21}, {C_RACK, 8'h00}, {C_RACK, 8'h00},
                  {C_RNAK, 8'h00}, {C_STOP, 8'h00}};
        check_log("rd", base);
        check("rd_pulse_count", 64'(rd_log.size() - rd_base), 64'd3);
        if (rd_log.size() - rd_base == 3) begin
            check("rd_byte0", 64'(rd_log[rd_base]),     64'({4'b0100, 8'h01}));
            check("rd_byte1", 64'(rd_log[rd_base + 1]), 64'({4'b0100, 8'h02}));
            check("rd_byte2", 64'(rd_log[rd_base + 2]), 64'({4'b0100, 8'h03}));
        end

        // Address NAK: STOP follows the address byte directly.
        @(negedge clk_i);
        nak_at = 1;
        base = cmd_log.size(); wp_base = wr_pulses;
        set_req(3, 7'h55, 1'b0, 4'd2);
        wait_done(d, e);
        nak_at = -1;
        check("nak_done", 64'({d, e}), 64'({4'b1000, 1'b1}));
        exp_q = '{{C_START, 8'h00}, {C_WRITE, 8'hAA}, {C_STOP, 8'h00}};
        check_log("nak", base);
        check("nak_no_wdata", 64'(wr_pulses - wp_base), 64'd0);

        // Backpressure: five stalled cycles per command.
        @(negedge clk_i);
        bp_cycles = 5;
        wbytes[0] = 8'h77;
        base = cmd_log.size(); n = stable_err;
        set_req(1, 7'h3C, 1'b0, 4'd1);
        wait_done(d, e);
        bp_cycles = 0;
        check("bp_done", 64'({d, e}), 64'({4'b0010, 1'b0}));
        exp_q = '{{C_START, 8'h00}, {C_WRITE, 8'h78}, {C_WRITE, 8'h77}, {C_STOP, 8'h00}};
        check_log("bp", base);
        check("bp_payload_stable", 64'(stable_err - n), 64'd0);

        // Reset in the middle of a read; rr_ptr was 2 beforehand.
        @(negedge clk_i);
        bp_cycles = 3;
        rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;
        rd_base = rd_log.size();
        set_req(2, 7'h10, 1'b1, 4'd3);
        n = 0;
        while (rd_log.size() == rd_base && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        if (rd_log.size() == rd_base) begin
            check("rst_rdata_timeout", 64'd0, 64'd1);
        end else begin
            check("rst_first_byte", 64'(rd_log[rd_base]), 64'({4'b0100, 8'h11}));
        end
        @(negedge clk_i);
        check("rst_pre_grant", 64'(grant_o), 64'(4'b0100));
        #2;
        rst_i = 1'b0;
        #1;
        check("rst_async_outputs", 64'({grant_o, cmd_valid_o, cmd_o, cmd_data_o, rdata_o,
              rdata_valid_o, wdata_ready_o, done_o, err_o}), 64'd0);
        req_i = '0;
        bp_cycles = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        set_req(1, 7'h0A, 1'b0, 4'd0);
        set_req(3, 7'h0B, 1'b0, 4'd0);
        wait_done(d, e); check("post_rst_first", 64'(d), 64'(4'b0010));
        wait_done(d, e); check("post_rst_second", 64'(d), 64'(4'b1000));

        check("no_early_command", 64'(early_err), 64'd0);
        check("payload_stable_total", 64'(stable_err), 64'd0);
        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
